hsync_generator: RTL and testbench

HSYNC_GENERATOR -- requirements
Module: hsync_generator

---
 rtl/hsync_generator_if.sv | 21 ++
 rtl/hsync_generator.sv | 113 +++++++++++
 tb/tb_hsync_generator.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hsync_generator_if.sv
// Horizontal timing outputs of hsync_generator, bundled for the vertical and pixel stages.
interface hsync_generator_if;
    logic HSYNC;
    logic hdisplay;
    logic twenty_enable;
    logic line_end;

    modport master (
        output HSYNC,
        output hdisplay,
        output twenty_enable,
        output line_end
    );

    modport slave (
        input HSYNC,
        input hdisplay,
        input twenty_enable,
        input line_end
    );
endinterface

// File: rtl/hsync_generator.sv
// Horizontal line timing: SYNC -> BACK_PORCH -> DISPLAY -> FRONT_PORCH, with a
// per-pixel strobe during DISPLAY and an end-of-line strobe for the vertical stage.
module hsync_generator #(
    parameter int SYNC_CYC = 384,
    parameter int BP_CYC   = 192,
    parameter int DISP_CYC = 2560,
    parameter int FP_CYC   = 64,
    parameter int PIX_DIV  = 20
) (
    input  logic              clk,
    input  logic              reset,
    hsync_generator_if.master tim
);

    localparam int LEN_MAX_A = (SYNC_CYC > BP_CYC) ? SYNC_CYC : BP_CYC;
    localparam int LEN_MAX_B = (DISP_CYC > FP_CYC) ? DISP_CYC : FP_CYC;
    localparam int LEN_MAX   = (LEN_MAX_A > LEN_MAX_B) ? LEN_MAX_A : LEN_MAX_B;
    localparam int CNT_W     = ($clog2(LEN_MAX) > 12) ? $clog2(LEN_MAX) : 12;
    localparam int DIV_W     = ($clog2(PIX_DIV) > 5) ? $clog2(PIX_DIV) : 5;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_CYC - 1);
    localparam logic [CNT_W-1:0] BP_LAST   = CNT_W'(BP_CYC - 1);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYC - 1);
    localparam logic [CNT_W-1:0] FP_LAST   = CNT_W'(FP_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        BACK_PORCH  = 2'd1,
        DISPLAY     = 2'd2,
        FRONT_PORCH = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;
    logic             hsync_nx;
    logic             hdisplay_nx;
    logic             te_nx;
    logic             le_nx;

    // Outputs are registered from the next-state decode, so each registered output
    // always equals the decode of the state/counters it is registered alongside.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CNT_W'(1);
        case (state)
            SYNC: begin
                if (cnt == SYNC_LAST) begin
                    cnt_nx   = '0;
                    state_nx = BACK_PORCH;
                end
            end
            BACK_PORCH: begin
                if (cnt == BP_LAST) begin
                    cnt_nx   = '0;
                    state_nx = DISPLAY;
                end
            end
            DISPLAY: begin
                if (cnt == DISP_LAST) begin
                    cnt_nx   = '0;
                    state_nx = FRONT_PORCH;
                end
            end
            FRONT_PORCH: begin
                if (cnt == FP_LAST) begin
                    cnt_nx   = '0;
                    state_nx = SYNC;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = SYNC;
            end
        endcase

        // Divider runs only while staying in DISPLAY; entering or leaving clears it.
        div_nx = '0;
        if (state == DISPLAY && state_nx == DISPLAY && div != DIV_LAST) begin
            div_nx = div + DIV_W'(1);
        end

        hsync_nx    = (state_nx != SYNC);
        hdisplay_nx = (state_nx == DISPLAY);
        te_nx       = (state_nx == DISPLAY) && (div_nx == DIV_LAST);
        le_nx       = (state_nx == FRONT_PORCH) && (cnt_nx == FP_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= SYNC;
            cnt                <= '0;
            div                <= '0;
            tim.HSYNC          <= 1'b0;
            tim.hdisplay       <= 1'b0;
            tim.twenty_enable  <= 1'b0;
            tim.line_end       <= 1'b0;
        end else begin
            state              <= state_nx;
            cnt                <= cnt_nx;
            div                <= div_nx;
            tim.HSYNC          <= hsync_nx;
            tim.hdisplay       <= hdisplay_nx;
            tim.twenty_enable  <= te_nx;
            tim.line_end       <= le_nx;
        end
    end

endmodule

// File: tb/tb_hsync_generator.sv
// Bench for hsync_generator: expected timing events are queued per DUT and a negedge
// monitor matches observed output edges/strobes against them.
module tb_hsync_generator;

    localparam int K_HS_FALL = 0;
    localparam int K_HS_RISE = 1;
    localparam int K_DE_RISE = 2;
    localparam int K_DE_FALL = 3;
    localparam int K_TE      = 4;
    localparam int K_LE      = 5;

    typedef struct {
        int n;
        int kind;
    } ev_t;

    logic clk;
    logic reset;
    logic mon_en;

    int   checks;
    int   errors;
    int   ncyc;
    int   te_line0 [2];
    logic prev_hs  [2];
    logic prev_de  [2];

    ev_t qa[$];
    ev_t qb[$];

    hsync_generator_if ifa ();
    hsync_generator_if ifb ();

    hsync_generator dut_a (
        .clk   (clk),
        .reset (reset),
        .tim   (ifa)
    );

    hsync_generator #(
        .SYNC_CYC (384),
        .BP_CYC   (192),
        .DISP_CYC (512),
        .FP_CYC   (64),
        .PIX_DIV  (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .tim   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_HS_FALL: return "HSYNC_fall";
            K_HS_RISE: return "HSYNC_rise";
            K_DE_RISE: return "hdisplay_rise";
            K_DE_FALL: return "hdisplay_fall";
            K_TE:      return "twenty_enable";
            K_LE:      return "line_end";
            default:   return "unknown";
        endcase
    endfunction

    task automatic push(input int d, input int n, input int kind, input int horizon);
        ev_t e;
        if (n >= horizon) return;
        e.n    = n;
        e.kind = kind;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    // Queue the events of every line starting before the horizon.
    task automatic push_lines(input int d, input int sync, input int bp, input int disp,
                              input int pdiv, input int fp, input int horizon);
        for (int base = 0; base < horizon; base += sync + bp + disp + fp) begin
            if (base > 0) push(d, base, K_HS_FALL, horizon);
            push(d, base + sync, K_HS_RISE, horizon);
            push(d, base + sync + bp, K_DE_RISE, horizon);
            for (int k = 0; k < 128; k++)
                push(d, base + sync + bp + pdiv - 1 + pdiv * k, K_TE, horizon);
            push(d, base + sync + bp + disp, K_DE_FALL, horizon);
            push(d, base + sync + bp + disp + fp - 1, K_LE, horizon);
        end
    endtask

    task automatic check_event(input int d, input int kind);
        ev_t e;
        checks++;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            errors++;
            $display("FAIL event dut%0d: saw %s at n=%0d, none expected", d, kname(kind), ncyc);
        end else begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            if (e.n != ncyc || e.kind != kind) begin
                errors++;
                $display("FAIL event dut%0d: saw %s at n=%0d, expected %s at n=%0d",
                         d, kname(kind), ncyc, kname(e.kind), e.n);
            end
        end
    endtask

    task automatic observe(input int d, input logic hs, input logic de,
                           input logic te, input logic le);
        if (prev_hs[d] && !hs) check_event(d, K_HS_FALL);
        if (!prev_hs[d] && hs) check_event(d, K_HS_RISE);
        if (!prev_de[d] && de) check_event(d, K_DE_RISE);
        if (prev_de[d] && !de) check_event(d, K_DE_FALL);
        if (te) check_event(d, K_TE);
        if (le) check_event(d, K_LE);
        if (te || le) begin
            checks++;
            if ((te && le) || !hs) begin
                errors++;
                $display("FAIL exclusive dut%0d n=%0d: te=%b le=%b HSYNC=%b, required one strobe with HSYNC=1",
                         d, ncyc, te, le, hs);
            end
        end
        if (te && ncyc < ((d == 0) ? 3200 : 1152)) te_line0[d]++;
        prev_hs[d] = hs;
        prev_de[d] = de;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " A HSYNC"},         32'(ifa.HSYNC),         32'd0);
        check_val({tag, " A hdisplay"},      32'(ifa.hdisplay),      32'd0);
        check_val({tag, " A twenty_enable"}, 32'(ifa.twenty_enable), 32'd0);
        check_val({tag, " A line_end"},      32'(ifa.line_end),      32'd0);
        check_val({tag, " B HSYNC"},         32'(ifb.HSYNC),         32'd0);
        check_val({tag, " B hdisplay"},      32'(ifb.hdisplay),      32'd0);
        check_val({tag, " B twenty_enable"}, 32'(ifb.twenty_enable), 32'd0);
        check_val({tag, " B line_end"},      32'(ifb.line_end),      32'd0);
    endtask

    // Monitor: sample cycle n on the negedge before edge n.
    always @(negedge clk) begin
        if (!mon_en) begin
            ncyc       = 0;
            prev_hs[0] = 1'b0;
            prev_hs[1] = 1'b0;
            prev_de[0] = 1'b0;
            prev_de[1] = 1'b0;
        end else begin
            observe(0, ifa.HSYNC, ifa.hdisplay, ifa.twenty_enable, ifa.line_end);
            observe(1, ifb.HSYNC, ifb.hdisplay, ifb.twenty_enable, ifb.line_end);
            ncyc++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        ncyc        = 0;
        te_line0[0] = 0;
        te_line0[1] = 0;
        reset       = 1'b0;
        mon_en      = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("in reset");

        // Run into the middle of DISPLAY, then hit reset asynchronously.
        push_lines(0, 384, 192, 2560, 20, 64, 1000);
        push_lines(1, 384, 192, 512, 4, 64, 1000);
        @(posedge clk);
        #2;
        reset  = 1'b1;
        mon_en = 1'b1;

        wait (ncyc == 1000);
        @(posedge clk);
        #2;
        check_val("pre-reset A hdisplay", 32'(ifa.hdisplay), 32'd1);
        check_val("pre-reset A twenty_enable", 32'(ifa.twenty_enable), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("async reset");
        check_val("phase1 A events left", 32'(qa.size()), 32'd0);
        check_val("phase1 B events left", 32'(qb.size()), 32'd0);
        qa.delete();
        qb.delete();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset held");

        // Ten full lines of DUT A from a clean restart.
        push_lines(0, 384, 192, 2560, 20, 64, 32000);
        push_lines(1, 384, 192, 512, 4, 64, 32000);
        te_line0[0] = 0;
        te_line0[1] = 0;
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        wait (ncyc == 32000);
        #1;
        mon_en = 1'b0;
        check_val("phase2 A events left", 32'(qa.size()), 32'd0);
        check_val("phase2 B events left", 32'(qb.size()), 32'd0);
        check_val("A strobes in line 0", 32'(te_line0[0]), 32'd128);
        check_val("B strobes in line 0", 32'(te_line0[1]), 32'd128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
